path_oram_ctrl: RTL

Parametrised Path ORAM controller with on-chip tree, stash and position map. It serves one oblivious read or write at a time over a valid/ready request/response interface. Every access reads one full root-to-leaf path into the stash, remaps the block to a fresh pseudo-random leaf, then greedily evicts the stash back along the same path. It is the cycle-accurate successor to the behavioural single-cycle ORAM model and drops into the same core-side slot.

---
 rtl/oram_pkg.sv | 32 +++
 rtl/oram_leaf_lfsr.sv | 34 +++
 rtl/path_oram_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oram_pkg.sv
// -----------------------------------------------------------------------------
// oram_pkg
// Shared definitions for the Path ORAM controller:
//   - oram_state_e   : controller FSM states
//   - ORAM_LFSR_POLY : Galois tap mask for x^16+x^14+x^13+x^11+1 (right-shift form)
//   - bucket_index() : flat bucket number of level `level` on the path to `leaf`
// The slot/entry record layouts depend on the controller's ADDR_W/DATA_W
// parameters, so they are declared inside path_oram_ctrl.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package oram_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_READ_PATH,
        ST_UPDATE,
        ST_EVICT,
        ST_RESP
    } oram_state_e;

    localparam logic [15:0] ORAM_LFSR_POLY = 16'hB400;

    // Heap-ordered tree: level lvl starts at bucket 2^lvl - 1, and the bucket
    // on the path to `leaf` is selected by the top `level` bits of the leaf.
    function automatic int unsigned bucket_index(input int unsigned level,
                                                 input int unsigned leaf,
                                                 input int unsigned addr_w);
        return ((32'd1 << level) - 32'd1) + (leaf >> (addr_w - level));
    endfunction

endpackage

// File: rtl/oram_leaf_lfsr.sv
// -----------------------------------------------------------------------------
// oram_leaf_lfsr
// Free-running 16-bit Galois LFSR used to draw fresh leaf labels.
// Advances every cycle while rst is low; loads SEED on reset.
// Ports:
//   clk    : clock
//   rst    : asynchronous active-high reset
//   o_leaf : low OUT_W bits of the current LFSR state
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module oram_leaf_lfsr
    import oram_pkg::*;
#(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    output logic [OUT_W-1:0] o_leaf
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? ORAM_LFSR_POLY : 16'h0000);
        end
    end

    assign o_leaf = r_lfsr[OUT_W-1:0];

endmodule

// File: rtl/path_oram_ctrl.sv
// -----------------------------------------------------------------------------
// path_oram_ctrl
// Path ORAM controller with on-chip tree, stash and position map. Serves one
// read or write at a time: reads the whole root-to-leaf path into the stash,
// updates/remaps the requested block, then greedily evicts back along the path.
// Optional feature macro: ORAM_STAT_EN (access counter + stash high-water mark).
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   req_valid/req_ready           : request handshake
//   req_write, req_addr, req_wdata: operation, block number, write payload
//   rsp_valid/rsp_ready           : response handshake
//   rsp_rdata                     : block value before this access (0 if never written)
//   stash_overflow                : sticky, cleared only by reset
//   stat_accesses, stat_stash_peak: statistics (0 unless ORAM_STAT_EN)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module path_oram_ctrl
    import oram_pkg::*;
#(
    parameter int          ADDR_W      = 3,
    parameter int          DATA_W      = 32,
    parameter int          Z           = 4,
    parameter int          STASH_DEPTH = 16,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [ADDR_W-1:0]                req_addr,
    input  logic [DATA_W-1:0]                req_wdata,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_W-1:0]                rsp_rdata,
    output logic                             stash_overflow,
    output logic [31:0]                      stat_accesses,
    output logic [$clog2(STASH_DEPTH+1)-1:0] stat_stash_peak
);

    localparam int N          = 1 << ADDR_W;
    localparam int BUCKETS    = (1 << (ADDR_W + 1)) - 1;
    localparam int TREE_SLOTS = BUCKETS * Z;
    localparam int TIDX_W     = $clog2(TREE_SLOTS);
    localparam int SLOT_W     = (Z > 1) ? $clog2(Z) : 1;
    localparam int SIDX_W     = (STASH_DEPTH > 1) ? $clog2(STASH_DEPTH) : 1;
    localparam int LVL_W      = 5;
    localparam int OCC_W      = $clog2(STASH_DEPTH + 1);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] leaf;
        logic [DATA_W-1:0] data;
    } stash_entry_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] leaf;
        logic [DATA_W-1:0] data;
    } tree_slot_t;

    // Lowest set bit of a stash flag vector.
    function automatic logic [SIDX_W-1:0] first_set(input logic [STASH_DEPTH-1:0] v);
        logic [SIDX_W-1:0] idx;
        idx = '0;
        for (int i = STASH_DEPTH - 1; i >= 0; i--) begin
            if (v[i]) idx = SIDX_W'(i);
        end
        return idx;
    endfunction

    oram_state_e       r_state, w_state_next;
    logic [TIDX_W-1:0] r_init_cnt;
    logic [LVL_W-1:0]  r_lvl;
    logic [SLOT_W-1:0] r_slot;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_leaf;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_overflow;

    stash_entry_t      r_stash  [STASH_DEPTH];
    tree_slot_t        r_tree   [TREE_SLOTS];
    logic [ADDR_W-1:0] r_posmap [N];

    logic [ADDR_W-1:0]      w_new_leaf;
    logic [TIDX_W-1:0]      w_tidx;
    tree_slot_t             w_rd_slot;
    logic [LVL_W-1:0]       w_shift;
    logic [STASH_DEPTH-1:0] w_free, w_hit, w_evq;
    logic                   w_free_any, w_hit_any, w_evq_any;
    logic [SIDX_W-1:0]      w_free_idx, w_hit_idx, w_evq_idx;
    logic                   w_rd_last, w_ev_last;

    oram_leaf_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (ADDR_W)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .o_leaf (w_new_leaf)
    );

    // Slot currently addressed on the latched path (read and evict share it).
    assign w_tidx    = TIDX_W'(bucket_index(32'(r_lvl), 32'(r_leaf), ADDR_W) * Z + 32'(r_slot));
    assign w_rd_slot = r_tree[w_tidx];
    // A block may sit at level lvl only if its leaf shares the top lvl bits with the path.
    assign w_shift   = LVL_W'(ADDR_W) - r_lvl;

    generate
        for (genvar gi = 0; gi < STASH_DEPTH; gi++) begin : g_stash_flags
            assign w_free[gi] = ~r_stash[gi].valid;
            assign w_hit[gi]  = r_stash[gi].valid && (r_stash[gi].addr == r_addr);
            assign w_evq[gi]  = r_stash[gi].valid &&
                                ((r_stash[gi].leaf >> w_shift) == (r_leaf >> w_shift));
        end
    endgenerate

    assign w_free_any = |w_free;
    assign w_hit_any  = |w_hit;
    assign w_evq_any  = |w_evq;
    assign w_free_idx = first_set(w_free);
    assign w_hit_idx  = first_set(w_hit);
    assign w_evq_idx  = first_set(w_evq);

    assign w_rd_last = (r_lvl == LVL_W'(ADDR_W)) && (r_slot == SLOT_W'(Z - 1));
    assign w_ev_last = (r_lvl == '0) && (r_slot == SLOT_W'(Z - 1));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_INIT;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_init_cnt == TIDX_W'(TREE_SLOTS - 1)) w_state_next = ST_IDLE;
            end
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_next = ST_READ_PATH;
            end
            ST_READ_PATH: begin
                if (w_rd_last) w_state_next = ST_UPDATE;
            end
            ST_UPDATE: begin
                w_state_next = ST_EVICT;
            end
            ST_EVICT: begin
                if (w_ev_last) w_state_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_INIT;
        endcase
    end

    // ------------------------------------------------- control + stash
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_init_cnt  <= '0;
            r_lvl       <= '0;
            r_slot      <= '0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_leaf      <= '0;
            r_wdata     <= '0;
            r_rsp_rdata <= '0;
            r_overflow  <= 1'b0;
            for (int i = 0; i < STASH_DEPTH; i++) r_stash[i] <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_init_cnt <= r_init_cnt + TIDX_W'(1);
                    for (int i = 0; i < STASH_DEPTH; i++) r_stash[i] <= '0;
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_leaf  <= r_posmap[req_addr];
                        r_lvl   <= '0;
                        r_slot  <= '0;
                    end
                end
                ST_READ_PATH: begin
                    if (w_rd_slot.valid) begin
                        if (w_free_any) r_stash[w_free_idx] <= stash_entry_t'(w_rd_slot);
                        else            r_overflow <= 1'b1;
                    end
                    if (r_slot == SLOT_W'(Z - 1)) begin
                        r_slot <= '0;
                        r_lvl  <= r_lvl + LVL_W'(1);
                    end else begin
                        r_slot <= r_slot + SLOT_W'(1);
                    end
                end
                ST_UPDATE: begin
                    r_rsp_rdata <= w_hit_any ? r_stash[w_hit_idx].data : '0;
                    if (w_hit_any) begin
                        r_stash[w_hit_idx].leaf <= w_new_leaf;
                        if (r_write) r_stash[w_hit_idx].data <= r_wdata;
                    end else if (r_write) begin
                        if (w_free_any) begin
                            r_stash[w_free_idx] <= '{valid: 1'b1, addr: r_addr,
                                                     leaf: w_new_leaf, data: r_wdata};
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end
                    r_lvl  <= LVL_W'(ADDR_W);
                    r_slot <= '0;
                end
                ST_EVICT: begin
                    if (w_evq_any) r_stash[w_evq_idx].valid <= 1'b0;
                    if (r_slot == SLOT_W'(Z - 1)) begin
                        r_slot <= '0;
                        r_lvl  <= r_lvl - LVL_W'(1);
                    end else begin
                        r_slot <= r_slot + SLOT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------- tree and position map
    // Contents are rebuilt in INIT after every reset, so no reset is needed here.
    always_ff @(posedge clk) begin
        case (r_state)
            ST_INIT:      r_tree[r_init_cnt] <= '0;
            ST_READ_PATH: r_tree[w_tidx]     <= '0;
            ST_EVICT:     r_tree[w_tidx]     <= w_evq_any ? tree_slot_t'(r_stash[w_evq_idx]) : '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            for (int i = 0; i < N; i++) r_posmap[i] <= ADDR_W'(i);
        end else if (r_state == ST_UPDATE) begin
            r_posmap[r_addr] <= w_new_leaf;
        end
    end

    assign rsp_rdata      = r_rsp_rdata;
    assign stash_overflow = r_overflow;

    // ---------------------------------------------------------- statistics
`ifdef ORAM_STAT_EN
    logic [31:0]      r_stat_accesses;
    logic [OCC_W-1:0] r_stat_peak;
    logic [OCC_W-1:0] w_occ;

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < STASH_DEPTH; i++) begin
            if (r_stash[i].valid) w_occ = w_occ + OCC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_accesses <= '0;
            r_stat_peak     <= '0;
        end else begin
            if ((r_state == ST_RESP) && rsp_ready && (r_stat_accesses != 32'hFFFF_FFFF))
                r_stat_accesses <= r_stat_accesses + 32'd1;
            if (w_occ > r_stat_peak)
                r_stat_peak <= w_occ;
        end
    end

    assign stat_accesses   = r_stat_accesses;
    assign stat_stash_peak = r_stat_peak;
`else
    assign stat_accesses   = '0;
    assign stat_stash_peak = '0;
`endif

endmodule
